// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline constants: datapath width, instruction-memory geometry,
// primary opcodes and the fetch-queue state encoding.
package mips32_pkg;

    localparam int XLEN    = 32;
    localparam int IMEM_AW = 10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        INSTR_R,
        INSTR_I,
        INSTR_J
    } instr_type_t;

    typedef enum logic [1:0] {
        FQ_IDLE,
        FQ_WAIT,
        FQ_DROP
    } fetch_state_t;

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with single-cycle flush. Storage is reset so the head reads
// zero out of reset.
module mips32_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch front-end: keeps one imem read in flight and queues each
// returned word with its next-PC for decode; redirects flush and drop stale data.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              AW       = IMEM_AW,
    parameter logic [XLEN-1:0] RESET_PC = 32'd0
) (
    input  logic                       clk1,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic                       imem_valid,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       halt,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_ir,
    output logic [XLEN-1:0]            id_npc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t      state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head;

    // The request is combinational so a fetch goes out in the same cycle the FSM
    // becomes idle; rst_n gates it so nothing is requested while held in reset.
    assign issue     = rst_n && (state == FQ_IDLE) && !halt && !redirect && (occupancy != FULL);
    assign imem_req  = issue;
    assign imem_addr = issue ? pc[AW-1:0] : '0;

    assign push     = (state == FQ_WAIT) && imem_valid && !redirect;
    assign pop      = id_valid && id_ready && !redirect;
    assign id_valid = (occupancy != '0);
    assign id_ir    = head[2*XLEN-1:XLEN];
    assign id_npc   = head[XLEN-1:0];

    mips32_sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .din   ({imem_rdata, req_pc + XLEN'(1)}),
        .pop   (pop),
        .dout  (head),
        .count (occupancy)
    );

    // A redirect always retargets pc; an outstanding response it orphans is
    // either discarded on the spot or later from DROP.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FQ_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                pc <= redirect_pc;
            end
            unique case (state)
                FQ_IDLE: begin
                    if (issue) begin
                        req_pc <= pc;
                        state  <= FQ_WAIT;
                    end
                end
                FQ_WAIT: begin
                    if (redirect) begin
                        state <= imem_valid ? FQ_IDLE : FQ_DROP;
                    end else if (imem_valid) begin
                        pc    <= req_pc + XLEN'(1);
                        state <= FQ_IDLE;
                    end
                end
                FQ_DROP: begin
                    if (imem_valid) begin
                        state <= FQ_IDLE;
                    end
                end
                default: state <= FQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed and randomized bench for mips32_fetch_queue, checked every cycle
// against a transaction-level fetch model with a queue of {ir, npc}.
module tb_mips32_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          AW       = 10;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam int          CW       = $clog2(DEPTH+1);

    logic          clk1        = 1'b0;
    logic          rst_n       = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid  = 1'b0;
    logic [31:0]   imem_rdata  = 32'd0;
    logic          redirect    = 1'b0;
    logic [31:0]   redirect_pc = 32'd0;
    logic          halt        = 1'b0;
    logic          id_valid;
    logic          id_ready    = 1'b0;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic [CW-1:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued {ir, npc}, fetch pc, and the one outstanding read.
    logic [63:0] mq[$];
    logic [31:0] m_pc     = RESET_PC;
    logic [31:0] m_req_pc = RESET_PC;
    bit          m_busy   = 0;
    bit          m_stale  = 0;
    bit          m_issued = 0;

    // Instruction memory: answers one request after its latency with addr+100.
    bit            mem_pending = 0;
    int            mem_cnt     = 0;
    logic [AW-1:0] mem_addr    = '0;
    int            lat         = 1;
    bit            rand_lat    = 0;
    int            req_seen    = 0;

    mips32_fetch_queue #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_ir       (id_ir),
        .id_npc      (id_npc),
        .occupancy   (occupancy)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Compares the DUT against the model for this cycle, then advances the model
    // across the coming clock edge using the inputs now being driven.
    task automatic checkOutput();
        logic        exp_req;
        logic [63:0] head;
        m_issued = 0;
        if (imem_req === 1'b1) req_seen++;
        if (!rst_n) begin
            check("rst_imem_req",  32'(imem_req),  32'd0);
            check("rst_imem_addr", 32'(imem_addr), 32'd0);
            check("rst_id_valid",  32'(id_valid),  32'd0);
            check("rst_id_ir",     id_ir,          32'd0);
            check("rst_id_npc",    id_npc,         32'd0);
            check("rst_occupancy", 32'(occupancy), 32'd0);
            mq.delete();
            m_pc    = RESET_PC;
            m_busy  = 0;
            m_stale = 0;
            return;
        end
        exp_req = !m_busy && !halt && !redirect && (mq.size() < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_pc[AW-1:0]));
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("id_valid", 32'(id_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            check("id_ir",  id_ir,  head[63:32]);
            check("id_npc", id_npc, head[31:0]);
        end
        if (imem_valid && m_busy && !m_stale && !redirect)
            check("push_not_full", 32'(occupancy != CW'(DEPTH)), 32'd1);

        if (redirect) begin
            mq.delete();
            m_pc = redirect_pc;
            if (m_busy) begin
                if (imem_valid) begin
                    m_busy  = 0;
                    m_stale = 0;
                end else begin
                    m_stale = 1;
                end
            end
        end else begin
            if (id_ready && mq.size() != 0) void'(mq.pop_front());
            if (m_busy && imem_valid) begin
                if (!m_stale) begin
                    mq.push_back({32'(m_req_pc[AW-1:0]) + 32'd100, m_req_pc + 32'd1});
                    m_pc = m_req_pc + 32'd1;
                end
                m_busy  = 0;
                m_stale = 0;
            end else if (exp_req) begin
                m_busy      = 1;
                m_req_pc    = m_pc;
                m_issued    = 1;
                mem_pending = 1;
                mem_addr    = m_pc[AW-1:0];
                mem_cnt     = (rand_lat ? int'($urandom_range(1, 4)) : lat) - 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc,
                                 input logic hlt, input logic rdy);
        @(posedge clk1);
        #1;
        rst_n       = rst;
        redirect    = rdr;
        redirect_pc = rpc;
        halt        = hlt;
        id_ready    = rdy;
        imem_valid  = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (mem_pending) begin
            if (mem_cnt == 0) begin
                imem_valid  = 1'b1;
                imem_rdata  = 32'(mem_addr) + 32'd100;
                mem_pending = 0;
            end else begin
                mem_cnt--;
            end
        end
        @(negedge clk1);
        checkOutput();
    endtask

    task automatic doReset();
        mem_pending = 0;
        rand_lat    = 0;
        repeat (2) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic runUntilIssue(input logic [31:0] addr, input logic rdy, input string name);
        int k   = 0;
        bit hit = 0;
        while (!hit && k < 60) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, rdy);
            hit = m_issued && (m_req_pc == addr);
            k++;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic runUntilValid(input logic rdy, input string name);
        int k   = 0;
        bit hit = 0;
        while (!hit && k < 30) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, rdy);
            hit = (id_valid === 1'b1);
            k++;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    initial begin
        logic [31:0] first_ir;
        bit          got_ir;
        bit          hlt;
        bit          hit;
        logic [31:0] rpc;
        int          k;

        // Streaming at L=1 with decode always ready.
        doReset();
        lat = 1;
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s1_first_req",  32'(imem_req),  32'd1);
        check("s1_first_addr", 32'(imem_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s1_ir0",   id_ir,            32'd100);
        check("s1_npc0",  id_npc,           32'd1);
        check("s1_req1",  32'(imem_req),    32'd1);
        check("s1_addr1", 32'(imem_addr),   32'd1);
        req_seen = 0;
        repeat (20) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s1_rate", 32'(req_seen), 32'd10);

        // Back-pressure fills the queue, then draining resumes fetch at addr 4.
        doReset();
        lat      = 1;
        req_seen = 0;
        repeat (10) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("s2_reqs",  32'(req_seen),  32'd4);
        check("s2_occ",   32'(occupancy), 32'd4);
        check("s2_no5th", 32'(imem_req),  32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s2_head", id_ir, 32'd100);
        k   = 0;
        hit = 0;
        while (!hit && k < 10) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
            hit = (imem_req === 1'b1);
            k++;
        end
        check("s2_resume",      32'(hit),       32'd1);
        check("s2_resume_addr", 32'(imem_addr), 32'd4);

        // Redirect while waiting on addr 5 at L=3: the response is dropped.
        doReset();
        lat = 3;
        runUntilIssue(32'd5, 1'b1, "s3_reach5");
        applyStimulus(1'b1, 1'b1, 32'd40, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s3_flushed", 32'(id_valid), 32'd0);
        check("s3_noreq_a", 32'(imem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s3_noreq_b", 32'(imem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s3_req",  32'(imem_req),  32'd1);
        check("s3_addr", 32'(imem_addr), 32'd40);
        runUntilValid(1'b1, "s3_valid");
        check("s3_ir",  id_ir,  32'd140);
        check("s3_npc", id_npc, 32'd41);

        // Redirect coinciding with the response.
        doReset();
        lat = 1;
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'd8, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s4_occ",  32'(occupancy), 32'd0);
        check("s4_req",  32'(imem_req),  32'd1);
        check("s4_addr", 32'(imem_addr), 32'd8);
        runUntilValid(1'b1, "s4_valid");
        check("s4_ir",  id_ir,  32'd108);
        check("s4_npc", id_npc, 32'd9);

        // Halt with addr 2 outstanding: response still lands, no new fetch.
        doReset();
        lat = 3;
        runUntilIssue(32'd2, 1'b1, "s5_reach2");
        req_seen = 0;
        got_ir   = 0;
        first_ir = 32'd0;
        repeat (8) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
            if (id_valid === 1'b1 && !got_ir) begin
                first_ir = id_ir;
                got_ir   = 1;
            end
        end
        check("s5_halt_noreq", 32'(req_seen), 32'd0);
        check("s5_pushed",     first_ir,      32'd102);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check("s5_req",  32'(imem_req),  32'd1);
        check("s5_addr", 32'(imem_addr), 32'd3);

        // Reset while waiting with two entries; the late response is ignored.
        doReset();
        lat = 3;
        k   = 0;
        hit = 0;
        while (!hit && k < 40) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            hit = m_issued && (mq.size() == 2);
            k++;
        end
        check("s6_reach", 32'(hit), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("s6_occ0",   32'(occupancy), 32'd0);
        check("s6_valid0", 32'(id_valid),  32'd0);
        check("s6_ir0",    id_ir,          32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("s6_req",  32'(imem_req),  32'd1);
        check("s6_addr", 32'(imem_addr), 32'(RESET_PC[AW-1:0]));
        runUntilValid(1'b0, "s6_valid");
        check("s6_ir",  id_ir,  32'd100);
        check("s6_npc", id_npc, 32'd1);

        // Random traffic: redirects (some near the 32-bit wrap), halt, stalls, L=1..4.
        doReset();
        rand_lat = 1;
        hlt      = 0;
        for (int c = 0; c < 4000; c++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                               : $urandom;
            if ($urandom_range(0, 15) == 0) hlt = !hlt;
            applyStimulus(1'b1, $urandom_range(0, 19) == 0, rpc, hlt,
                          $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
